// File: rtl/glycemic_index_tracker.sv
// Glycemic index engine: accepts a signed sample and forms its two's-complement
// magnitude. It counts the magnitude's set bits one per clock, then presents the
// index, a threshold alarm and a running peak.
module glycemic_index_tracker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [WIDTH-1:0] sample_data,
    input  logic [IDX_W-1:0] threshold,
    output logic             index_valid,
    input  logic             index_ready,
    output logic [IDX_W-1:0] index,
    output logic             alarm,
    output logic [IDX_W-1:0] peak,
    input  logic             peak_clear
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ABS   = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   sample_q, sample_d;
    logic [IDX_W-1:0]   thresh_q, thresh_d;
    logic [WIDTH-1:0]   shreg_q,  shreg_d;
    logic [IDX_W-1:0]   acc_q,    acc_d;
    logic [IDX_W-1:0]   bitcnt_q, bitcnt_d;
    logic [IDX_W-1:0]   index_q,  index_d;
    logic               alarm_q,  alarm_d;
    logic [IDX_W-1:0]   peak_q,   peak_d;
    logic               done_entry;

    // State and datapath registers; reset aborts any sample in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sample_q <= '0;
            thresh_q <= '0;
            shreg_q  <= '0;
            acc_q    <= '0;
            bitcnt_q <= '0;
            index_q  <= '0;
            alarm_q  <= 1'b0;
            peak_q   <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            thresh_q <= thresh_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            bitcnt_q <= bitcnt_d;
            index_q  <= index_d;
            alarm_q  <= alarm_d;
            peak_q   <= peak_d;
        end
    end

    // Next-state and datapath update; fixed WIDTH-cycle count, no early exit
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        thresh_d   = thresh_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        bitcnt_d   = bitcnt_q;
        index_d    = index_q;
        alarm_d    = alarm_q;
        peak_d     = peak_q;
        done_entry = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    sample_d = sample_data;
                    thresh_d = threshold;
                    state_d  = S_ABS;
                end
            end
            S_ABS: begin
                // Most-negative value wraps to itself, giving an index of 1
                shreg_d  = sample_q[WIDTH-1] ? (~sample_q + WIDTH'(1)) : sample_q;
                acc_d    = '0;
                bitcnt_d = '0;
                state_d  = S_COUNT;
            end
            S_COUNT: begin
                acc_d    = acc_q + IDX_W'(shreg_q[0]);
                shreg_d  = shreg_q >> 1;
                bitcnt_d = bitcnt_q + IDX_W'(1);
                if (bitcnt_q == IDX_W'(WIDTH - 1)) begin
                    index_d    = acc_d;
                    alarm_d    = (acc_d >= thresh_q);
                    done_entry = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (index_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Peak tracking; a clear on the result edge restarts from the new index
        if (done_entry) begin
            if (peak_clear || (index_d > peak_q)) begin
                peak_d = index_d;
            end
        end else if (peak_clear) begin
            peak_d = '0;
        end
    end

    // Handshake flags decode from state only; data outputs come from registers
    assign sample_ready = (state_q == S_IDLE);
    assign index_valid  = (state_q == S_DONE);
    assign index        = index_q;
    assign alarm        = alarm_q;
    assign peak         = peak_q;

endmodule

// File: tb/tb_glycemic_index_tracker.sv
// Directed bench for glycemic_index_tracker at WIDTH=8 and WIDTH=12.
module tb_glycemic_index_tracker;

    logic        clk = 1'b0;
    logic        rst_n;

    // WIDTH=8 instance signals
    logic        v8, rdy8, iv8, ir8, alm8, pc8;
    logic [7:0]  d8;
    logic [3:0]  t8, idx8, pk8;

    // WIDTH=12 instance signals
    logic        v12, rdy12, iv12, ir12, alm12, pc12;
    logic [11:0] d12;
    logic [3:0]  t12, idx12, pk12;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    glycemic_index_tracker #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(v8), .sample_ready(rdy8), .sample_data(d8), .threshold(t8),
        .index_valid(iv8), .index_ready(ir8), .index(idx8), .alarm(alm8),
        .peak(pk8), .peak_clear(pc8)
    );

    glycemic_index_tracker #(.WIDTH(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(v12), .sample_ready(rdy12), .sample_data(d12), .threshold(t12),
        .index_valid(iv12), .index_ready(ir12), .index(idx12), .alarm(alm12),
        .peak(pk12), .peak_clear(pc12)
    );

    // Single comparison point: counts and reports every check
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one sample, wait (bounded) for index_valid; optional peak_clear on the result edge
    task automatic send(input int w, input logic [11:0] data, input logic [3:0] thr,
                        input bit clr_at_done, output int lat,
                        output logic [3:0] idx, output logic alm, output logic [3:0] pk);
        @(negedge clk);
        if (w == 8) begin v8 = 1'b1; d8 = data[7:0]; t8 = thr; end
        else        begin v12 = 1'b1; d12 = data; t12 = thr; end
        @(posedge clk); #1;
        v8  = 1'b0;
        v12 = 1'b0;
        lat = 0;
        while (((w == 8) ? iv8 : iv12) !== 1'b1 && lat < 40) begin
            if (clr_at_done && lat == w) pc8 = 1'b1;
            @(posedge clk); #1;
            pc8 = 1'b0;
            lat++;
        end
        idx = (w == 8) ? idx8 : idx12;
        alm = (w == 8) ? alm8 : alm12;
        pk  = (w == 8) ? pk8  : pk12;
    endtask

    // Accept the pending index for one cycle
    task automatic consume(input int w);
        @(negedge clk);
        if (w == 8) ir8 = 1'b1; else ir12 = 1'b1;
        @(posedge clk); #1;
        ir8  = 1'b0;
        ir12 = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [3:0]  idx, pk;
        logic        alm;

        rst_n = 1'b0;
        v8 = 0; d8 = '0; t8 = '0; ir8 = 0; pc8 = 0;
        v12 = 0; d12 = '0; t12 = '0; ir12 = 0; pc12 = 0;
        #1;
        check_eq("rst_sample_ready", 32'(rdy8), 32'd1);
        check_eq("rst_index_valid",  32'(iv8),  32'd0);
        check_eq("rst_index",        32'(idx8), 32'd0);
        check_eq("rst_alarm",        32'(alm8), 32'd0);
        check_eq("rst_peak",         32'(pk8),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x05 thr 3 -> index 2, no alarm, latency 9
        send(8, 12'h005, 4'd3, 1'b0, lat, idx, alm, pk);
        check_eq("s05_lat",   32'(lat), 32'd9);
        check_eq("s05_index", 32'(idx), 32'd2);
        check_eq("s05_alarm", 32'(alm), 32'd0);
        check_eq("s05_peak",  32'(pk),  32'd2);
        consume(8);
        check_eq("s05_ready_after", 32'(rdy8), 32'd1);

        // Clear peak before the 1 -> 1 -> 7 sequence
        @(negedge clk); pc8 = 1'b1;
        @(posedge clk); #1; pc8 = 1'b0;
        check_eq("clr_peak", 32'(pk8), 32'd0);

        // -1 with threshold 0 always alarms
        send(8, 12'h0FF, 4'd0, 1'b0, lat, idx, alm, pk);
        check_eq("sFF_index", 32'(idx), 32'd1);
        check_eq("sFF_alarm", 32'(alm), 32'd1);
        check_eq("sFF_peak",  32'(pk),  32'd1);
        consume(8);

        // Most-negative maps to itself -> index 1
        send(8, 12'h080, 4'd2, 1'b0, lat, idx, alm, pk);
        check_eq("s80_lat",   32'(lat), 32'd9);
        check_eq("s80_index", 32'(idx), 32'd1);
        check_eq("s80_alarm", 32'(alm), 32'd0);
        check_eq("s80_peak",  32'(pk),  32'd1);
        consume(8);

        // 0x7F thr 7 -> index 7 alarm; then hold off the consumer for 6 cycles
        send(8, 12'h07F, 4'd7, 1'b0, lat, idx, alm, pk);
        check_eq("s7F_index", 32'(idx), 32'd7);
        check_eq("s7F_alarm", 32'(alm), 32'd1);
        check_eq("s7F_peak",  32'(pk),  32'd7);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v8 = 1'b1; d8 = 8'h01; t8 = 4'd0;
            @(posedge clk); #1;
            check_eq("bp_index",        32'(idx8), 32'd7);
            check_eq("bp_alarm",        32'(alm8), 32'd1);
            check_eq("bp_sample_ready", 32'(rdy8), 32'd0);
            check_eq("bp_index_valid",  32'(iv8),  32'd1);
        end
        v8 = 1'b0;
        consume(8);
        check_eq("bp_released", 32'(rdy8), 32'd1);

        // peak_clear on the result edge of 0x03 -> peak becomes 2
        send(8, 12'h003, 4'd1, 1'b1, lat, idx, alm, pk);
        check_eq("s03_index", 32'(idx), 32'd2);
        check_eq("s03_alarm", 32'(alm), 32'd1);
        check_eq("s03_peak",  32'(pk),  32'd2);
        consume(8);

        // Reset in the middle of counting 0x7F
        @(negedge clk);
        v8 = 1'b1; d8 = 8'h7F; t8 = 4'd7;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sample_ready", 32'(rdy8), 32'd1);
        check_eq("mid_rst_index_valid",  32'(iv8),  32'd0);
        check_eq("mid_rst_index",        32'(idx8), 32'd0);
        check_eq("mid_rst_alarm",        32'(alm8), 32'd0);
        check_eq("mid_rst_peak",         32'(pk8),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("mid_rst_no_result", 32'(iv8), 32'd0);

        send(8, 12'h001, 4'd1, 1'b0, lat, idx, alm, pk);
        check_eq("s01_lat",   32'(lat), 32'd9);
        check_eq("s01_index", 32'(idx), 32'd1);
        check_eq("s01_alarm", 32'(alm), 32'd1);
        check_eq("s01_peak",  32'(pk),  32'd1);
        consume(8);

        // peak_clear with no result pending -> 0
        @(negedge clk); pc8 = 1'b1;
        @(posedge clk); #1; pc8 = 1'b0;
        check_eq("clr_alone_peak", 32'(pk8), 32'd0);

        // WIDTH=12: most-negative and max-positive, latency 13
        send(12, 12'h800, 4'd1, 1'b0, lat, idx, alm, pk);
        check_eq("w12_800_lat",   32'(lat), 32'd13);
        check_eq("w12_800_index", 32'(idx), 32'd1);
        check_eq("w12_800_alarm", 32'(alm), 32'd1);
        check_eq("w12_800_peak",  32'(pk),  32'd1);
        consume(12);

        send(12, 12'h7FF, 4'd12, 1'b0, lat, idx, alm, pk);
        check_eq("w12_7FF_lat",   32'(lat), 32'd13);
        check_eq("w12_7FF_index", 32'(idx), 32'd11);
        check_eq("w12_7FF_alarm", 32'(alm), 32'd0);
        check_eq("w12_7FF_peak",  32'(pk),  32'd11);
        consume(12);
        check_eq("w12_ready_after", 32'(rdy12), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/glycemic_index_tracker.md
# glycemic_index_tracker

Sequential, parametrised glycemic index engine for the healthcare datapath. It accepts signed blood-sensor samples over a valid/ready handshake and forms the magnitude in two's complement. It counts the set bits of that magnitude serially, one bit per clock, then presents the resulting glycemic index with a threshold alarm and a running peak. It sits between the sensor front end and the alert/display logic, and replaces the fixed 8-bit combinational calculator.

## Interface
- WIDTH, 8: sample width in bits, signed two's complement; legal range 2..32.
- IDX_W, $clog2(WIDTH+1): index/threshold/peak width (derived; do not override).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  block can accept a sample; high only in IDLE.
- sample_data  in  WIDTH  signed blood-sensor sample.
- threshold  in  IDX_W  alarm threshold; sampled with the accepted sample.
- index_valid  out  1  index/alarm valid; held until consumed.
- index_ready  in  1  consumer accepts index.
- index  out  IDX_W  popcount of |sample_data|.
- alarm  out  1  index >= captured threshold; meaningful while index_valid.
- peak  out  IDX_W  maximum index produced since reset or last peak_clear.
- peak_clear  in  1  synchronous clear of peak.

## Operation
- FSM states: IDLE, ABS, COUNT, DONE.
- IDLE: sample_ready=1. If sample_valid, then capture sample_data and threshold and go to ABS.
- ABS: magnitude = msb ? (~x + 1) : x, truncated to WIDTH bits. Load the shift register with the magnitude. Clear the accumulator and the bit counter. Go to COUNT.
- Most-negative input (1 followed by zeros) maps to itself, so its index is 1. This is the required behaviour; do not saturate.
- COUNT: each cycle, accumulator += shreg[0], shreg >>= 1, bitcnt += 1. After exactly WIDTH count cycles, register index, alarm and peak, then go to DONE. There is no early exit on shreg==0; latency is fixed.
- DONE: index_valid=1. index and alarm are stable until index_valid && index_ready, which returns the FSM to IDLE.
- alarm = (index >= captured threshold). A threshold of 0 always alarms.
- peak update occurs at the DONE-entry edge: peak = max(peak, new index).
- peak_clear in a cycle without a DONE-entry: peak becomes 0.
- peak_clear coinciding with a DONE-entry edge: peak becomes the new index.
- Inputs sample_valid and sample_data are ignored outside IDLE. The sample is never overwritten mid-computation.

## Timing
- Reset values: state IDLE, sample_ready 1, index_valid 0, index 0, alarm 0, peak 0, internal registers 0.
- Asynchronous assertion of rst_n aborts any operation immediately. A sample in flight is discarded and no index is produced.
- Reset deassertion is synchronised by the surrounding design. The first accept can occur on the first rising edge after rst_n goes high.
- Acceptance at edge E0 leads to ABS after E0, then COUNT from E1 through E(WIDTH).
- index_valid rises after edge E(WIDTH+1), i.e. latency is WIDTH+1 clocks from accept.
- Minimum sample-to-sample period is WIDTH+3 clocks: one DONE cycle with index_ready high, then one IDLE cycle.
- index_ready may be held high permanently. The index is then valid for exactly one cycle.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

## Test plan
- WIDTH=8, sample 0x05, threshold 3: index=2, alarm=0, index_valid exactly 9 clocks after accept, peak=2.
- WIDTH=8, samples 0xFF (-1) then 0x80 (-128): both give index=1. 0x7F with threshold 7 gives index=7, alarm=1, and peak goes 1→1→7.
- Backpressure: hold index_ready low for 6 cycles after index_valid. index/alarm must stay stable, sample_ready must stay 0, and a sample presented meanwhile must not be accepted.
- With peak=7, assert peak_clear on the DONE-entry edge of a sample 0x03: peak=2. A peak_clear alone afterwards gives peak=0.
- Drop rst_n during COUNT of sample 0x7F: all outputs return to reset values immediately. After release, a new sample 0x01 gives index=1 and peak=1.
- WIDTH=12, sample 0x800 gives index=1 and sample 0x7FF gives index=11, each with latency 13 clocks; IDX_W=4.
